cpu_core: RTL and testbench



---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_alu.sv | 75 +++++++
 rtl/cpu_core.sv | 112 +++++++++++
 tb/tb_cpu_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the WISC-S18 single-cycle core.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_RED    = 4'h2,
        OP_XOR    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        CC_NE     = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GE     = 3'b100,
        CC_LE     = 3'b101,
        CC_OVF    = 3'b110,
        CC_ALWAYS = 3'b111
    } cond_t;

    function automatic logic cond_met(cond_t cc, logic z, logic v, logic n);
        case (cc)
            CC_NE:   return !z;
            CC_EQ:   return z;
            CC_GT:   return !z && !n;
            CC_LT:   return n;
            CC_GE:   return z || (!z && !n);
            CC_LE:   return n || z;
            CC_OVF:  return v;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub with overflow, xor and immediate shifts.
// Define CPU_SAT_ARITH_EN to make ADD/SUB saturate on signed overflow.
module cpu_alu
    import cpu_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        imm4,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              v,
    output logic              n,
    output logic              z_we,
    output logic              v_we,
    output logic              n_we
);

    logic              is_sub;
    logic              ovf;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] arith;
    logic [DATA_W-1:0] ror_val;

    // Subtraction reuses the adder as a + ~b + 1, so one overflow rule covers both.
    assign is_sub  = (op == OP_SUB);
    assign b_eff   = is_sub ? ~b : b;
    assign sum     = a + b_eff + {{(DATA_W-1){1'b0}}, is_sub};
    assign ovf     = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    assign ror_val = (a >> imm4) | (a << (5'd16 - {1'b0, imm4}));

`ifdef CPU_SAT_ARITH_EN
    assign arith = ovf ? (a[DATA_W-1] ? 16'h8000 : 16'h7FFF) : sum;
`else
    assign arith = sum;
`endif

    always_comb begin
        result = '0;
        z_we   = 1'b0;
        v_we   = 1'b0;
        n_we   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result = arith;
                z_we   = 1'b1;
                v_we   = 1'b1;
                n_we   = 1'b1;
            end
            OP_XOR: begin
                result = a ^ b;
                z_we   = 1'b1;
            end
            OP_SLL: begin
                result = a << imm4;
                z_we   = 1'b1;
            end
            OP_SRA: begin
                result = $signed(a) >>> imm4;
                z_we   = 1'b1;
            end
            OP_ROR: begin
                result = ror_val;
                z_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign z = (result == '0);
    assign n = result[DATA_W-1];
    assign v = ovf;

endmodule

// File: rtl/cpu_core.sv
// Single-cycle WISC-S18 core: PC, register file, flags, memories and branch logic.
// ADD/SUB saturation is selected inside cpu_alu by CPU_SAT_ARITH_EN.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int    IMEM_AW   = 8,
    parameter int    DMEM_AW   = 8,
    parameter string IMEM_FILE = "instructions.mif"
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] pc_out,
    output logic              hlt
);

    localparam int IMEM_WORDS = 1 << IMEM_AW;
    localparam int DMEM_WORDS = 1 << DMEM_AW;

    logic [DATA_W-1:0] imem [0:IMEM_WORDS-1];
    logic [DATA_W-1:0] dmem [0:DMEM_WORDS-1] = '{default: '0};
    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    logic [DATA_W-1:0]  pc_reg, pc_next, pc_inc, br_target;
    logic               hlt_reg, z_reg, v_reg, n_reg;
    logic [DATA_W-1:0]  instr;
    opcode_t            op;
    logic [3:0]         rd_addr, rs_addr, b_addr;
    logic [DATA_W-1:0]  rs_val, b_val, wb_data, alu_result;
    logic [DMEM_AW-1:0] dmem_idx;
    logic               alu_z, alu_v, alu_n, alu_z_we, alu_v_we, alu_n_we;
    logic               taken, reg_we;

    assign instr   = imem[pc_reg[IMEM_AW:1]];
    assign op      = opcode_t'(instr[15:12]);
    assign rd_addr = instr[11:8];
    assign rs_addr = instr[7:4];
    // SW stores, and LLB/LHB merge into, the register named in [11:8].
    assign b_addr  = (op == OP_SW || op == OP_LLB || op == OP_LHB) ? rd_addr : instr[3:0];
    assign rs_val  = (rs_addr == 4'd0) ? '0 : regs[rs_addr];
    assign b_val   = (b_addr == 4'd0) ? '0 : regs[b_addr];

    assign dmem_idx  = rs_val[DMEM_AW:1] + {{(DMEM_AW-4){instr[3]}}, instr[3:0]};
    assign pc_inc    = pc_reg + 16'd2;
    assign br_target = pc_inc + {{6{instr[8]}}, instr[8:0], 1'b0};
    assign taken     = cond_met(cond_t'(instr[11:9]), z_reg, v_reg, n_reg);

    cpu_alu u_alu (
        .op     (op),
        .a      (rs_val),
        .b      (b_val),
        .imm4   (instr[3:0]),
        .result (alu_result),
        .z      (alu_z),
        .v      (alu_v),
        .n      (alu_n),
        .z_we   (alu_z_we),
        .v_we   (alu_v_we),
        .n_we   (alu_n_we)
    );

    always_comb begin
        pc_next = pc_inc;
        if (hlt_reg || op == OP_HLT)  pc_next = pc_reg;
        else if (op == OP_B && taken)  pc_next = br_target;
        else if (op == OP_BR && taken) pc_next = rs_val;
    end

    always_comb begin
        reg_we  = 1'b0;
        wb_data = alu_result;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR: reg_we = 1'b1;
            OP_LW:  begin reg_we = 1'b1; wb_data = dmem[dmem_idx]; end
            OP_LLB: begin reg_we = 1'b1; wb_data = {b_val[15:8], instr[7:0]}; end
            OP_LHB: begin reg_we = 1'b1; wb_data = {instr[7:0], b_val[7:0]}; end
            OP_PCS: begin reg_we = 1'b1; wb_data = pc_inc; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg  <= '0;
            hlt_reg <= 1'b0;
            z_reg   <= 1'b0;
            v_reg   <= 1'b0;
            n_reg   <= 1'b0;
        end else if (!hlt_reg) begin
            pc_reg <= pc_next;
            if (op == OP_HLT) hlt_reg <= 1'b1;
            if (alu_z_we)     z_reg   <= alu_z;
            if (alu_v_we)     v_reg   <= alu_v;
            if (alu_n_we)     n_reg   <= alu_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (!hlt_reg && reg_we && rd_addr != 4'd0) begin
            regs[rd_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !hlt_reg && op == OP_SW) dmem[dmem_idx] <= b_val;
    end

    assign pc_out = pc_reg;
    assign hlt    = hlt_reg;

endmodule

// File: tb/tb_cpu_core.sv
// Scenario bench for cpu_core: loads small programs, queues expected state, compares after execution.
module tb_cpu_core;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_out;
    logic        hlt;

    cpu_core #(.IMEM_AW(8), .DMEM_AW(8), .IMEM_FILE("")) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc_out (pc_out),
        .hlt    (hlt)
    );

    always #5 clk = ~clk;

    localparam int K_PC = 0, K_HLT = 1, K_REG = 2, K_Z = 3, K_V = 4, K_N = 5, K_MEM = 6;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t    sb[$];
    logic [15:0] prog[$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic void expect_val(string name, int kind, int idx, logic [15:0] exp);
        sb.push_back('{name, kind, idx, exp});
    endfunction

    function automatic logic [15:0] observe(int kind, int idx);
        logic [3:0] ri;
        logic [7:0] mi;
        ri = idx[3:0];
        mi = idx[7:0];
        case (kind)
            K_PC:    return pc_out;
            K_HLT:   return {15'd0, hlt};
            K_REG:   return dut.regs[ri];
            K_Z:     return {15'd0, dut.z_reg};
            K_V:     return {15'd0, dut.v_reg};
            K_N:     return {15'd0, dut.n_reg};
            default: return dut.dmem[mi];
        endcase
    endfunction

    task automatic load_and_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) dut.imem[8'(i)] = 16'hF000;
        foreach (prog[i]) dut.imem[8'(i)] = prog[i];
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hF000};
        load_and_reset();
        expect_val("rst_pc", K_PC, 0, 16'h0000);
        expect_val("rst_hlt", K_HLT, 0, 16'h0000);
        expect_val("rst_z", K_Z, 0, 16'h0000);
        expect_val("rst_v", K_V, 0, 16'h0000);
        expect_val("rst_n_flag", K_N, 0, 16'h0000);
        expect_val("rst_r1", K_REG, 1, 16'h0000);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    task automatic test_load_imm();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hA134, 16'hB112, 16'hA055, 16'h0201, 16'hF000};
        load_and_reset();
        run(2);
        expect_val("llb_lhb_r1", K_REG, 1, 16'h1234);
        expect_val("llb_lhb_pc", K_PC, 0, 16'h0004);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
        run(3);
        expect_val("r0_reads_zero_add", K_REG, 2, 16'h1234);
        expect_val("r0_storage", K_REG, 0, 16'h0000);
        expect_val("load_hlt_pc", K_PC, 0, 16'h0008);
        expect_val("load_hlt", K_HLT, 0, 16'h0001);
        expect_val("add_v_clear", K_V, 0, 16'h0000);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    task automatic test_sat_add();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hA1FF, 16'hB17F, 16'hA201, 16'hA500, 16'hB580,
                 16'h1652, 16'h0312, 16'hF000};
        load_and_reset();
        run(8);
`ifdef CPU_SAT_ARITH_EN
        expect_val("sub_neg_ovf", K_REG, 6, 16'h8000);
        expect_val("add_pos_ovf", K_REG, 3, 16'h7FFF);
        expect_val("add_ovf_n", K_N, 0, 16'h0000);
`else
        expect_val("sub_neg_ovf", K_REG, 6, 16'h7FFF);
        expect_val("add_pos_ovf", K_REG, 3, 16'h8000);
        expect_val("add_ovf_n", K_N, 0, 16'h0001);
`endif
        expect_val("add_ovf_v", K_V, 0, 16'h0001);
        expect_val("add_ovf_z", K_Z, 0, 16'h0000);
        expect_val("sat_pc", K_PC, 0, 16'h000E);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    task automatic test_memory();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hA134, 16'hB112, 16'hA410, 16'h9142, 16'h8542,
                 16'h944F, 16'h884F, 16'hAA13, 16'h8BA1, 16'hF000};
        load_and_reset();
        run(10);
        expect_val("sw_mem_0x14", K_MEM, 10, 16'h1234);
        expect_val("lw_after_sw", K_REG, 5, 16'h1234);
        expect_val("sw_neg_off_mem", K_MEM, 7, 16'h0010);
        expect_val("lw_neg_off", K_REG, 8, 16'h0010);
        expect_val("lw_odd_base", K_REG, 11, 16'h1234);
        expect_val("mem_pc", K_PC, 0, 16'h0012);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    task automatic test_branch();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hA105, 16'hA205, 16'h1312, 16'hC203, 16'hACEE, 16'hACEE,
                 16'hACEE, 16'hC003, 16'hA640, 16'hDE60, 16'hACEE};
        load_and_reset();
        dut.imem[8'd32] = 16'hAD77;
        run(9);
        expect_val("br_final_pc", K_PC, 0, 16'h0042);
        expect_val("br_skipped", K_REG, 12, 16'h0000);
        expect_val("br_target_ran", K_REG, 13, 16'h0077);
        expect_val("sub_z_set", K_Z, 0, 16'h0001);
        expect_val("br_hlt", K_HLT, 0, 16'h0001);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    task automatic test_wrap();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hA6FC, 16'hB6FF, 16'hDE60, 16'hACEE, 16'hF000};
        load_and_reset();
        dut.imem[8'd254] = 16'hE700;
        dut.imem[8'd255] = 16'hCE04;
        run(6);
        expect_val("wrap_pcs", K_REG, 7, 16'hFFFE);
        expect_val("wrap_pc", K_PC, 0, 16'h0008);
        expect_val("wrap_skipped", K_REG, 12, 16'h0000);
        expect_val("wrap_hlt", K_HLT, 0, 16'h0001);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    task automatic test_pcs_shift();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hB180, 16'hA201, 16'h531F, 16'h4424, 16'hE500,
                 16'h3722, 16'h6621, 16'hF000};
        load_and_reset();
        run(8);
        expect_val("sra_8000_15", K_REG, 3, 16'hFFFF);
        expect_val("sll_1_4", K_REG, 4, 16'h0010);
        expect_val("pcs_at_8", K_REG, 5, 16'h000A);
        expect_val("xor_self", K_REG, 7, 16'h0000);
        expect_val("ror_1_1", K_REG, 6, 16'h8000);
        expect_val("ror_z", K_Z, 0, 16'h0000);
        expect_val("shift_n_held", K_N, 0, 16'h0000);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    task automatic test_halt_reset();
        sb_item_t it;
        logic [15:0] got;
        prog = '{16'hA1AB, 16'hA2CD, 16'hA3EF, 16'hA401, 16'hA502,
                 16'hA603, 16'hF000, 16'hA7FF};
        load_and_reset();
        for (int c = 1; c <= 12; c++) begin
            expect_val("halt_pc_trace", K_PC, 0, (c < 7) ? 16'(2 * c) : 16'h000C);
            expect_val("halt_flag_trace", K_HLT, 0, (c >= 7) ? 16'h0001 : 16'h0000);
            run(1);
            while (sb.size() != 0) begin
                it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
                if (got !== it.exp) begin
                    miscompares++; $display("FAIL %s: cycle %0d observed %h expected %h", it.name, c, got, it.exp);
                end else $display("  ok %s cycle %0d = %h", it.name, c, got);
            end
        end
        expect_val("halt_r1_kept", K_REG, 1, 16'h00AB);
        expect_val("halt_r6_kept", K_REG, 6, 16'h0003);
        expect_val("halt_no_exec_past", K_REG, 7, 16'h0000);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        expect_val("rst_clears_hlt", K_HLT, 0, 16'h0000);
        expect_val("rst_restart_pc", K_PC, 0, 16'h0000);
        expect_val("rst_clears_r1", K_REG, 1, 16'h0000);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
        run(1);
        expect_val("restart_pc", K_PC, 0, 16'h0002);
        expect_val("restart_r1", K_REG, 1, 16'h00AB);
        while (sb.size() != 0) begin
            it = sb.pop_front(); got = observe(it.kind, it.idx); vectors++;
            if (got !== it.exp) begin
                miscompares++; $display("FAIL %s: observed %h expected %h", it.name, got, it.exp);
            end else $display("  ok %s = %h", it.name, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_imm();
        test_sat_add();
        test_memory();
        test_branch();
        test_wrap();
        test_pcs_shift();
        test_halt_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
